// File: rtl/nlfsr_search_ctrl_if.sv
// Signal bundle between the NLFSR search sequencer and its host, feedback selector,
// NLFSR and result consumer.
interface nlfsr_search_ctrl_if #(
    parameter int unsigned CAND_W = 12
);
    logic              start;
    logic [CAND_W-1:0] cand_first;
    logic [CAND_W-1:0] cand_last;
    logic              sel_load;
    logic [CAND_W-1:0] sel_cand;
    logic              sel_done;
    logic              nlfsr_res;
    logic              nlfsr_ena;
    logic              nlfsr_found;
    logic              nlfsr_failure;
    logic              hit_valid;
    logic [CAND_W-1:0] hit_cand;
    logic              hit_ready;
    logic              busy;
    logic              done;
    logic [CAND_W:0]   hit_count;
    logic              wd_err;

    modport master (
        input  start, cand_first, cand_last, sel_done, nlfsr_found, nlfsr_failure, hit_ready,
        output sel_load, sel_cand, nlfsr_res, nlfsr_ena, hit_valid, hit_cand,
               busy, done, hit_count, wd_err
    );

    modport slave (
        output start, cand_first, cand_last, sel_done, nlfsr_found, nlfsr_failure, hit_ready,
        input  sel_load, sel_cand, nlfsr_res, nlfsr_ena, hit_valid, hit_cand,
               busy, done, hit_count, wd_err
    );
endinterface

// File: rtl/nlfsr_search_ctrl.sv
// Sequencer for an exhaustive full-period search over NLFSR feedback candidates:
// reset, load selector, run with watchdog, report full-period hits.
module nlfsr_search_ctrl #(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned CAND_W   = 12,
    parameter int unsigned WD_SLACK = 8
) (
    input  logic                clk,
    input  logic                res,
    nlfsr_search_ctrl_if.master bus
);

    localparam int unsigned         CNT_W     = SIZE + 2;
    localparam logic [CNT_W-1:0]    WD_LIMIT  = CNT_W'((32'd1 << SIZE) + WD_SLACK);
    localparam logic [CAND_W-1:0]   CAND_MAX  = '1;
    localparam logic [CAND_W:0]     HITS_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SELECT,
        S_RUN,
        S_REPORT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CAND_W-1:0] cur;
    logic [CAND_W-1:0] last;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_cnt_nxt;

    // Run cycles only count while the selector reports ready.
    assign run_cnt_nxt = run_cnt + CNT_W'(bus.sel_done);

    always_ff @(posedge clk) begin
        if (res) begin
            state         <= S_IDLE;
            cur           <= '0;
            last          <= '0;
            run_cnt       <= '0;
            bus.sel_load  <= 1'b0;
            bus.sel_cand  <= '0;
            bus.nlfsr_res <= 1'b0;
            bus.nlfsr_ena <= 1'b0;
            bus.hit_valid <= 1'b0;
            bus.hit_cand  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.hit_count <= '0;
            bus.wd_err    <= 1'b0;
        end else begin
            bus.sel_load  <= 1'b0;
            bus.nlfsr_res <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        cur           <= bus.cand_first;
                        last          <= bus.cand_last;
                        bus.hit_count <= '0;
                        bus.wd_err    <= 1'b0;
                        if (bus.cand_first > bus.cand_last) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state         <= S_CLEAR;
                            bus.done      <= 1'b0;
                            bus.busy      <= 1'b1;
                            bus.nlfsr_res <= 1'b1;
                            bus.sel_cand  <= bus.cand_first;
                        end
                    end
                end

                S_CLEAR: begin
                    run_cnt      <= '0;
                    bus.sel_load <= 1'b1;
                    state        <= S_SELECT;
                end

                // sel_load is high only in the first SELECT cycle; ignore sel_done there.
                S_SELECT: begin
                    if (!bus.sel_load && bus.sel_done) begin
                        bus.nlfsr_ena <= 1'b1;
                        state         <= S_RUN;
                    end
                end

                S_RUN: begin
                    run_cnt <= run_cnt_nxt;
                    if (bus.nlfsr_found) begin
                        bus.nlfsr_ena <= 1'b0;
                        bus.hit_valid <= 1'b1;
                        bus.hit_cand  <= cur;
                        state         <= S_REPORT;
                    end else if (bus.nlfsr_failure) begin
                        bus.nlfsr_ena <= 1'b0;
                        state         <= S_NEXT;
                    end else if (run_cnt_nxt == WD_LIMIT) begin
                        bus.nlfsr_ena <= 1'b0;
                        bus.wd_err    <= 1'b1;
                        state         <= S_NEXT;
                    end
                end

                S_REPORT: begin
                    if (bus.hit_ready) begin
                        bus.hit_valid <= 1'b0;
                        if (bus.hit_count != HITS_MAX) begin
                            bus.hit_count <= bus.hit_count + 1'b1;
                        end
                        state <= S_NEXT;
                    end
                end

                // The top index always terminates so cur never wraps.
                S_NEXT: begin
                    if (cur == last || cur == CAND_MAX) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        cur           <= cur + 1'b1;
                        bus.sel_cand  <= cur + 1'b1;
                        bus.nlfsr_res <= 1'b1;
                        state         <= S_CLEAR;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nlfsr_search_ctrl.md
Name: nlfsr_search_ctrl

Overview:
- Sequencer for an exhaustive full-period search over NLFSR feedback candidates.
- For each candidate index in [cand_first, cand_last], the block:
  - resets the NLFSR,
  - loads the candidate into the feedback selector and waits for it,
  - runs the register until it reports found or failure, or until a watchdog expires,
  - emits each full-period candidate on a valid/ready result port.
- Sits between the host/top-level control and one NLFSR plus its feedback-selector pair.

Parameters:
- SIZE, 16, NLFSR state width; nominal period is 2**SIZE.
- CAND_W, 12, width of the candidate index.
- WD_SLACK, 8, extra run cycles beyond 2**SIZE before the watchdog fires.

Ports:
- clk  in  1  system clock
- res  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a search, sampled in IDLE/DONE only
- cand_first  in  CAND_W  first candidate index, latched on start
- cand_last  in  CAND_W  last candidate index, latched on start
- sel_load  out  1  one-cycle pulse: selector loads sel_cand
- sel_cand  out  CAND_W  current candidate index
- sel_done  in  1  selector ready; must stay high while RUN is active
- nlfsr_res  out  1  reset to the NLFSR
- nlfsr_ena  out  1  enable to the NLFSR
- nlfsr_found  in  1  full period reached
- nlfsr_failure  in  1  short cycle or overrun
- hit_valid  out  1  result valid
- hit_cand  out  CAND_W  candidate with full period
- hit_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level; search complete
- hit_count  out  CAND_W+1  number of accepted hits in this search
- wd_err  out  1  sticky; watchdog fired at least once in this search

Behaviour:
- Reset (res=1, any state, has priority over everything):
  - state←IDLE
  - all outputs 0, including sel_cand, hit_cand, hit_count, wd_err and done
  - run counter cleared
- IDLE / DONE, on start:
  - latch cand_first → cur and cand_last → last
  - clear hit_count, wd_err and done
  - go to CLEAR
- start is ignored in every other state.
- Range check: if cand_first > cand_last at start, go directly to DONE with done=1 and perform no runs.
- CLEAR:
  - nlfsr_res=1 for exactly 1 cycle
  - run counter←0
  - sel_cand=cur
  - next state SELECT
- SELECT:
  - sel_load=1 on the first cycle of the state only
  - wait until sel_done=1 on a cycle after that pulse, then go to RUN
  - a sel_done that is already high during the pulse cycle does not count
- RUN:
  - nlfsr_ena=1
  - run counter increments every cycle in which sel_done=1
  - exits are evaluated in this priority order:
    - nlfsr_found=1 → REPORT
    - nlfsr_failure=1 → NEXT
    - counter == 2**SIZE + WD_SLACK → set wd_err, go to NEXT
  - nlfsr_ena drops in the same cycle the exit is registered (registered output, so it is low from the next cycle).
  - Counter width is SIZE+2 bits and must not wrap.
- REPORT:
  - hit_valid=1 and hit_cand=cur, both held stable until hit_ready=1
  - on the handshake cycle, hit_count increments (saturating at all-ones), then go to NEXT
  - hit_ready while hit_valid=0 has no effect.
- NEXT:
  - if cur == last → DONE, done=1
  - else cur←cur+1 → CLEAR
  - cur == 2**CAND_W − 1 always terminates; the index never wraps.
- DONE: done held at 1 until the next start or a reset.
- Latency: CLEAR (1 cycle) + SELECT (≥2 cycles) precede the first nlfsr_ena cycle of each candidate.
- Reset mid-run: all outputs are cleared on the next edge; the NLFSR is not explicitly reset by this path. The next start begins with CLEAR.

Test Plan:
- SIZE=4, range 3..3; selector acks 2 cycles after sel_load; NLFSR model asserts found at cycle 16 of RUN; hit_ready=1 → hit_valid for 1 cycle with hit_cand=3, hit_count=1, done=1, wd_err=0.
- Range 0..4; model fails candidates 0, 2, 4 and finds 1, 3; hit_ready held low 5 cycles on each hit → hits 1 then 3, in order, each held stable until accepted; hit_count=2.
- SIZE=4, WD_SLACK=8; model never responds → RUN exits after 24 counted cycles; wd_err=1; search continues to the next candidate.
- sel_done drops for 3 cycles mid-RUN → run counter pauses for those cycles; watchdog exit is delayed by exactly 3 cycles.
- res asserted during RUN of candidate 7 → next cycle IDLE with all outputs 0; a new start with range 7..7 completes normally.
- start with cand_first=5, cand_last=2 → done=1 within 2 cycles; no sel_load and no nlfsr_res pulses.
